countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The module SHALL have parameter MIN_DIGITS, default 1, giving the number of BCD minute digits; legal values are 1 to 3.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port clrn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port data, input, 4 bits: keypad digit.
REQ-005 The module SHALL have port loadn, input, 1 bit: active-low digit strobe, one digit per cycle held low.
REQ-006 The module SHALL have port start, input, 1 bit: start/resume request.
REQ-007 The module SHALL have port stop, input, 1 bit: pause/clear request.
REQ-008 The module SHALL have port en, input, 1 bit: one-second tick enable, one decrement per cycle with en high.
REQ-009 The module SHALL have port add30, input, 1 bit: add 0:30 request.
REQ-010 The module SHALL have port count, output, 4*(MIN_DIGITS+2) bits: packed BCD as {minutes MS..LS, sec_tens, sec_ones}.
REQ-011 The module SHALL have port zero, output, 1 bit: high when every count digit is 0.
REQ-012 The module SHALL have port running, output, 1 bit: high in RUN (magnetron enable).
REQ-013 The module SHALL have port done, output, 1 bit: registered one-cycle pulse on reaching 0:00.

Function
REQ-014 The block SHALL be a state machine with states IDLE, RUN, PAUSE and DONE.
REQ-015 In IDLE, loadn low with data <= 9 SHALL shift count left one digit and insert data as sec_ones; the MS digit is discarded.
REQ-016 loadn low with data > 9 SHALL be ignored; loadn SHALL be ignored outside IDLE and DONE.
REQ-017 Entry SHALL accept sec_tens values 6-9 unchanged; e.g. 0:90 is a valid 90 s count.
REQ-018 In IDLE or PAUSE, start with zero low SHALL go to RUN; start with zero high SHALL leave state and count unchanged.
REQ-019 In RUN, en high SHALL decrement count by one second: sec_ones 0->9 borrows, sec_tens 0->5 borrows, and minute digits borrow as BCD.
REQ-020 In RUN, a decrement producing 0:00 SHALL move to DONE and assert done for exactly the next cycle.
REQ-021 In RUN, stop SHALL go to PAUSE with count held; start SHALL be ignored.
REQ-022 In PAUSE, stop SHALL clear count to 0 and go to IDLE.
REQ-023 In IDLE, stop SHALL clear count to 0.
REQ-024 In DONE, count SHALL hold 0; start, stop or loadn low SHALL return to IDLE with no digit inserted.
REQ-025 When start and stop are asserted in the same cycle, stop SHALL win.
REQ-026 Priority SHALL be stop, then add30, then start/loadn, then en.
REQ-027 running SHALL be registered, equal to (state==RUN); zero SHALL be combinational from count.

Reset
REQ-028 clrn low SHALL immediately force state IDLE, count 0, running 0 and done 0, regardless of clock.
REQ-029 Reset asserted mid-RUN SHALL abort the count with no done pulse.

Configuration
REQ-030 With macro TIMER_ADD30_EN defined, add30 SHALL add 30 s in any state: sec_tens += 3; a result >= 12 SHALL subtract 12 and carry 2 into minutes, and a result >= 6 SHALL subtract 6 and carry 1; minutes add as BCD.
REQ-031 If a minutes overflow would occur, the count SHALL saturate at all-9 minutes :59.
REQ-032 add30 SHALL suppress that cycle's decrement; from IDLE, PAUSE or DONE it SHALL also go to RUN.
REQ-033 Without TIMER_ADD30_EN, add30 SHALL still exist as a port and SHALL be ignored; no add logic is built.

Verification
REQ-034 The bench SHALL cover: digits 1,3,0 via loadn, start, then 90 en ticks -> count 1:30, then 0:00 with one-cycle done pulse, running falls, state DONE.
REQ-035 The bench SHALL cover: load 9,0 (0:90), start, 1 tick -> 0:89; load 1,0,0, start, 1 tick -> 0:59.
REQ-036 The bench SHALL cover: RUN at 0:45, stop -> PAUSE holds 0:45 through en ticks; stop again -> IDLE, count 0.
REQ-037 The bench SHALL cover: IDLE at 0:00, start -> remains IDLE; start+stop together from PAUSE -> IDLE, count 0.
REQ-038 The bench SHALL cover, with TIMER_ADD30_EN: 0:90 +add30 -> 2:00; 9:45 +add30 (MIN_DIGITS=1) -> 9:59 saturated; IDLE 0:00 +add30 -> RUN at 0:30.
REQ-039 The bench SHALL cover: clrn pulsed low between clock edges during RUN -> count 0, IDLE, running 0 immediately, no done pulse.

Source files
------------

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Keypad-loaded BCD countdown timer (microwave style). Digits are shifted in
// from the right while idle, start/resume and pause/clear requests drive a
// four-state controller (IDLE, RUN, PAUSE, DONE), and each enabled tick in
// RUN removes one second. Reaching 0:00 produces a one-cycle done pulse.
//
// Optional feature macro: TIMER_ADD30_EN
//   defined   : add30 adds 0:30 in any state (saturating at 9..9:59), suppresses
//               that cycle's decrement and enters RUN.
//   undefined : add30 is present on the port list but has no effect.
//
// Parameters
//   MIN_DIGITS : number of BCD minute digits (1..3)
//
// Ports
//   clock   in   single clock, rising edge
//   clrn    in   asynchronous active-low reset
//   data    in   [3:0] keypad digit
//   loadn   in   active-low digit strobe (one digit per low cycle)
//   start   in   start / resume request
//   stop    in   pause / clear request (wins over everything)
//   en      in   one-second tick enable
//   add30   in   add 0:30 request
//   count   out  [4*(MIN_DIGITS+2)-1:0] {minutes MS..LS, sec_tens, sec_ones}
//   zero    out  all count digits are 0 (combinational)
//   running out  registered, high while in RUN
//   done    out  registered one-cycle pulse on reaching 0:00
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int MIN_DIGITS = 1
) (
  input  logic                          clock,
  input  logic                          clrn,
  input  logic [3:0]                    data,
  input  logic                          loadn,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          en,
  input  logic                          add30,
  output logic [4*(MIN_DIGITS+2)-1:0]   count,
  output logic                          zero,
  output logic                          running,
  output logic                          done
);

  localparam int W  = 4 * (MIN_DIGITS + 2);
  localparam int ND = MIN_DIGITS + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] cnt_dec;
  logic         done_nxt;

  // One-second BCD decrement. Digit 1 (sec_tens) wraps 0->5, every other
  // digit wraps 0->9. Entered sec_tens values 6..9 simply count down.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] c);
    logic [W-1:0] r;
    logic         borrow;
    logic [3:0]   d;
    r      = c;
    borrow = 1'b1;
    for (int i = 0; i < ND; i++) begin
      d = c[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d      = (i == 1) ? 4'd5 : 4'd9;
          borrow = 1'b1;
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

`ifdef TIMER_ADD30_EN
  // Add 0:30 with saturation. sec_tens may already hold 6..9, so the sum can
  // reach 12 and carry two minutes at once. A carry out of the top minute
  // digit pins the count at 9..9:59.
  function automatic logic [W-1:0] bcd_add30_sat(input logic [W-1:0] c);
    logic [W-1:0] r;
    logic [3:0]   t;
    logic [3:0]   d;
    logic [1:0]   carry;
    r = c;
    t = c[7:4] + 4'd3;
    if (t >= 4'd12) begin
      t     = t - 4'd12;
      carry = 2'd2;
    end else if (t >= 4'd6) begin
      t     = t - 4'd6;
      carry = 2'd1;
    end else begin
      carry = 2'd0;
    end
    r[7:4] = t;
    for (int i = 2; i < ND; i++) begin
      d = c[4*i +: 4] + {2'b00, carry};
      if (d >= 4'd10) begin
        d     = d - 4'd10;
        carry = 2'd1;
      end else begin
        carry = 2'd0;
      end
      r[4*i +: 4] = d;
    end
    if (carry != 2'd0) begin
      r = {{MIN_DIGITS{4'd9}}, 4'd5, 4'd9};
    end
    return r;
  endfunction
`else
  logic unused_add30;
  assign unused_add30 = add30;
`endif

  assign cnt_dec = bcd_dec(cnt);
  assign zero    = (cnt == '0);
  assign count   = cnt;

  // Next-state decode: stop, then add30, then start/loadn, then en.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    if (stop) begin
      if (state == ST_RUN) begin
        state_nxt = ST_PAUSE;
      end else begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    end
`ifdef TIMER_ADD30_EN
    else if (add30) begin
      cnt_nxt   = bcd_add30_sat(cnt);
      state_nxt = ST_RUN;
    end
`endif
    else begin
      case (state)
        ST_IDLE: begin
          // start takes precedence over a simultaneous digit strobe
          if (start) begin
            if (!zero) state_nxt = ST_RUN;
          end else if (!loadn && (data <= 4'd9)) begin
            cnt_nxt = {cnt[W-5:0], data};
          end
        end
        ST_RUN: begin
          if (en && !zero) begin
            cnt_nxt = cnt_dec;
            if (cnt_dec == '0) begin
              state_nxt = ST_DONE;
              done_nxt  = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (start && !zero) state_nxt = ST_RUN;
        end
        default: begin
          // DONE: leave on start or any digit strobe without inserting it
          cnt_nxt = '0;
          if (start || !loadn) state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Register stage: state, count and registered outputs
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      running <= (state_nxt == ST_RUN);
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Directed, table-driven bench for countdown_timer with MIN_DIGITS = 1
// (count is 12 bits: {min, sec_tens, sec_ones}). A table of single-cycle
// vectors covers loading, start/stop/pause behaviour and priority; hand
// sequences cover the full 1:30 countdown with done pulse, the asynchronous
// reset mid-run, and the add30 behaviour of whichever build is compiled.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  logic        clock;
  logic        clrn;
  logic [3:0]  data;
  logic        loadn;
  logic        start;
  logic        stop;
  logic        en;
  logic        add30;
  logic [11:0] count;
  logic        zero;
  logic        running;
  logic        done;

  int n_vec;
  int n_err;

  countdown_timer #(.MIN_DIGITS(1)) dut (
    .clock   (clock),
    .clrn    (clrn),
    .data    (data),
    .loadn   (loadn),
    .start   (start),
    .stop    (stop),
    .en      (en),
    .add30   (add30),
    .count   (count),
    .zero    (zero),
    .running (running),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        st;
    logic        sp;
    logic        ld_n;
    logic [3:0]  d;
    logic        e;
    logic        a30;
    logic [11:0] ec;
    logic        er;
    logic        ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic sp, input logic ld_n,
                              input logic [3:0] d, input logic e, input logic a30,
                              input logic [11:0] ec, input logic er);
    vec_t v;
    v.st = st; v.sp = sp; v.ld_n = ld_n; v.d = d; v.e = e; v.a30 = a30;
    v.ec = ec; v.er = er; v.ed = 1'b0;
    return v;
  endfunction

  function automatic logic [11:0] to_bcd(input int s);
    logic [3:0] m, t, o;
    m = 4'(s / 60);
    t = 4'((s % 60) / 10);
    o = 4'(s % 10);
    return {m, t, o};
  endfunction

  // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
  task automatic apply(input logic st, input logic sp, input logic ld_n,
                       input logic [3:0] d, input logic e, input logic a30);
    start = st; stop = sp; loadn = ld_n; data = d; en = e; add30 = a30;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] ec,
                       input logic er, input logic ed);
    logic ez;
    ez = (ec == 12'h000);
    n_vec++;
    if ({count, zero, running, done} !== {ec, ez, er, ed}) begin
      n_err++;
      $display("FAIL %s: got count=%h zero=%b running=%b done=%b, want count=%h zero=%b running=%b done=%b",
               tag, count, zero, running, done, ec, ez, er, ed);
    end
  endtask

  task automatic load(input logic [3:0] d);
    apply(1'b0, 1'b0, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    clrn = 1'b1; start = 1'b0; stop = 1'b0; loadn = 1'b1;
    data = 4'd0; en = 1'b0; add30 = 1'b0;

    // Reset takes effect before any clock edge
    #2 clrn = 1'b0;
    #1 check("reset_state", 12'h000, 1'b0, 1'b0);
    @(posedge clock);
    #1 clrn = 1'b1;
    check("after_reset_edge", 12'h000, 1'b0, 1'b0);

    //        st sp ldn d     e  a30  count   run
    vecs.push_back(mk(0, 0, 0, 4'd9, 0, 0, 12'h009, 0)); // load 9
    vecs.push_back(mk(0, 0, 0, 4'd0, 0, 0, 12'h090, 0)); // load 0 -> 0:90
    vecs.push_back(mk(1, 0, 1, 4'd0, 0, 0, 12'h090, 1)); // start
    vecs.push_back(mk(0, 0, 1, 4'd0, 1, 0, 12'h089, 1)); // tick -> 0:89
    vecs.push_back(mk(0, 0, 0, 4'd3, 0, 0, 12'h089, 1)); // loadn ignored in RUN
    vecs.push_back(mk(1, 0, 1, 4'd0, 0, 0, 12'h089, 1)); // start ignored in RUN
    vecs.push_back(mk(0, 1, 1, 4'd0, 0, 0, 12'h089, 0)); // stop -> PAUSE
    vecs.push_back(mk(0, 0, 1, 4'd0, 1, 0, 12'h089, 0)); // tick ignored in PAUSE
    vecs.push_back(mk(0, 0, 0, 4'd5, 0, 0, 12'h089, 0)); // loadn ignored in PAUSE
    vecs.push_back(mk(1, 0, 1, 4'd0, 0, 0, 12'h089, 1)); // resume
    vecs.push_back(mk(0, 0, 1, 4'd0, 1, 0, 12'h088, 1)); // tick
    vecs.push_back(mk(0, 1, 1, 4'd0, 0, 0, 12'h088, 0)); // PAUSE
    vecs.push_back(mk(0, 1, 1, 4'd0, 0, 0, 12'h000, 0)); // stop in PAUSE clears
    vecs.push_back(mk(0, 0, 0, 4'd10, 0, 0, 12'h000, 0)); // digit > 9 ignored
    vecs.push_back(mk(0, 0, 0, 4'd1, 0, 0, 12'h001, 0));
    vecs.push_back(mk(0, 0, 0, 4'd0, 0, 0, 12'h010, 0));
    vecs.push_back(mk(0, 0, 0, 4'd0, 0, 0, 12'h100, 0)); // 1:00
    vecs.push_back(mk(1, 0, 1, 4'd0, 0, 0, 12'h100, 1));
    vecs.push_back(mk(0, 0, 1, 4'd0, 1, 0, 12'h059, 1)); // minute borrow
    vecs.push_back(mk(0, 1, 1, 4'd0, 0, 0, 12'h059, 0)); // PAUSE
    vecs.push_back(mk(1, 1, 1, 4'd0, 0, 0, 12'h000, 0)); // start+stop in PAUSE
    vecs.push_back(mk(0, 0, 0, 4'd4, 0, 0, 12'h004, 0));
    vecs.push_back(mk(0, 0, 0, 4'd5, 0, 0, 12'h045, 0));
    vecs.push_back(mk(1, 0, 1, 4'd0, 0, 0, 12'h045, 1)); // RUN at 0:45
    vecs.push_back(mk(1, 1, 1, 4'd0, 0, 0, 12'h045, 0)); // start+stop: stop wins
    vecs.push_back(mk(0, 0, 1, 4'd0, 1, 0, 12'h045, 0)); // held in PAUSE
    vecs.push_back(mk(0, 0, 1, 4'd0, 1, 0, 12'h045, 0));
    vecs.push_back(mk(0, 1, 1, 4'd0, 0, 0, 12'h000, 0)); // stop again -> IDLE
    vecs.push_back(mk(1, 0, 1, 4'd0, 0, 0, 12'h000, 0)); // start at 0:00 ignored
    vecs.push_back(mk(0, 0, 1, 4'd0, 1, 0, 12'h000, 0));
    vecs.push_back(mk(0, 0, 0, 4'd7, 0, 0, 12'h007, 0));
    vecs.push_back(mk(0, 1, 1, 4'd0, 0, 0, 12'h000, 0)); // stop in IDLE clears
    vecs.push_back(mk(0, 0, 0, 4'd1, 0, 0, 12'h001, 0));
    vecs.push_back(mk(0, 0, 0, 4'd2, 0, 0, 12'h012, 0));
    vecs.push_back(mk(0, 0, 0, 4'd3, 0, 0, 12'h123, 0));
    vecs.push_back(mk(0, 0, 0, 4'd4, 0, 0, 12'h234, 0)); // MS digit dropped
    vecs.push_back(mk(0, 0, 1, 4'd0, 1, 0, 12'h234, 0)); // tick ignored in IDLE
    vecs.push_back(mk(0, 1, 1, 4'd0, 0, 0, 12'h000, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].st, vecs[i].sp, vecs[i].ld_n, vecs[i].d, vecs[i].e, vecs[i].a30);
      check($sformatf("vec%0d", i), vecs[i].ec, vecs[i].er, vecs[i].ed);
    end

    // Full countdown from 1:30 to 0:00 with done pulse
    load(4'd1); load(4'd3); load(4'd0);
    check("load_130", 12'h130, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    check("start_130", 12'h130, 1'b1, 1'b0);
    for (int i = 1; i <= 90; i++) begin
      apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
      check($sformatf("tick%0d", i), to_bcd(90 - i), (i < 90), (i == 90));
    end
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    check("done_one_cycle", 12'h000, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    check("done_start_ignored_zero", 12'h000, 1'b0, 1'b0);
    // Back in IDLE: another run to DONE, then leave with a digit strobe
    load(4'd2);
    apply(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    check("second_done", 12'h000, 1'b0, 1'b1);
    load(4'd5);
    check("done_loadn_no_insert", 12'h000, 1'b0, 1'b0);
    load(4'd5);
    check("idle_after_done", 12'h005, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);

    // Asynchronous reset between edges during RUN
    load(4'd5); load(4'd0);
    apply(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    check("run_before_reset", 12'h048, 1'b1, 1'b0);
    #2 clrn = 1'b0;
    #1 check("reset_mid_run_immediate", 12'h000, 1'b0, 1'b0);
    @(posedge clock);
    #1 check("reset_held", 12'h000, 1'b0, 1'b0);
    clrn = 1'b1;
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    check("after_reset_idle", 12'h000, 1'b0, 1'b0);

`ifdef TIMER_ADD30_EN
    load(4'd9); load(4'd0);
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    check("add30_090", 12'h200, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    check("add30_suppress_tick", 12'h230, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    load(4'd9); load(4'd4); load(4'd5);
    check("load_945", 12'h945, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    check("add30_saturate", 12'h959, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    check("cleared", 12'h000, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    check("add30_from_zero", 12'h030, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    check("add30_run_tick", 12'h029, 1'b1, 1'b0);
`else
    load(4'd9); load(4'd0);
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    check("add30_ignored_idle", 12'h090, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    check("add30_ignored_run", 12'h089, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    check("add30_ignored_zero", 12'h000, 1'b0, 1'b0);
`endif

    idle_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
